// File: rtl/rx_comando_valvula.sv
// -----------------------------------------------------------------------------
// rx_comando_valvula
//
// UART receiver and single-character command decoder for the RX line of the
// water-level controller. Bytes from the remote operator are deserialised
// and ASCII commands become one-cycle valve open/close pulses plus a
// manual-mode level that feed the valve logic.
//
// Build option:
//   RX_PARIDADE_EN  defined   -> frame is 8E1; parity bit checked.
//                   undefined -> frame is 8N1; erro_paridade tied to 0.
//
// Parameters:
//   CICLOS_POR_BIT  clock cycles per serial bit (>= 4)
//   MEIO_BIT        cycles from start-bit falling edge to first mid-bit sample
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   RX             in   asynchronous serial line, idle high
//   cmd_abre       out  one-cycle pulse: open valve
//   cmd_fecha      out  one-cycle pulse: close valve
//   modo_manual    out  level: remote manual control active
//   dado_recebido  out  last byte received without error
//   pronto_rx      out  one-cycle pulse: valid byte received
//   cmd_invalido   out  one-cycle pulse: valid byte that is not a command
//   erro_quadro    out  one-cycle pulse: stop bit sampled low
//   erro_paridade  out  one-cycle pulse: parity mismatch
//   db_estado      out  current FSM state code
// -----------------------------------------------------------------------------
module rx_comando_valvula #(
    parameter int CICLOS_POR_BIT = 434,
    parameter int MEIO_BIT       = CICLOS_POR_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic       cmd_abre,
    output logic       cmd_fecha,
    output logic       modo_manual,
    output logic [7:0] dado_recebido,
    output logic       pronto_rx,
    output logic       cmd_invalido,
    output logic       erro_quadro,
    output logic       erro_paridade,
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(CICLOS_POR_BIT) + 1;
    localparam logic [CW-1:0] RECARGA_BIT  = CW'(CICLOS_POR_BIT - 1);
    localparam logic [CW-1:0] RECARGA_MEIO = CW'(MEIO_BIT - 1);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        INICIO      = 4'd1,
        DADOS       = 4'd2,
        PARIDADE    = 4'd3,
        PARADA      = 4'd4,
        DECODIFICA  = 4'd5,
        ESPERA_ALTO = 4'd6
    } estado_t;

    estado_t       r_estado;
    estado_t       w_prox;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_ant;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_nbit;
    logic [7:0]    r_shift;
    logic [7:0]    r_dado;
    logic          r_modo;
    logic          r_abre;
    logic          r_fecha;
    logic          r_pronto;
    logic          r_invalido;
    logic          r_erro_quadro;

    logic          w_borda;
    logic          w_amostra;
    logic          w_carrega_meio;
    logic          w_carrega_bit;
    logic          w_desloca;
    logic          w_carga_dado;
    logic          w_modo_prox;
    logic          w_abre;
    logic          w_fecha;
    logic          w_pronto;
    logic          w_invalido;
    logic          w_erro_quadro;
    logic          w_byte_ok;

`ifdef RX_PARIDADE_EN
    logic          r_par_falha;
    logic          r_erro_par;
    logic          w_amostra_par;
    logic          w_erro_par;
`endif

    // Two-flop synchroniser plus one delayed copy for edge detection.
    // Idle-high reset values keep a reset release from looking like a start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_ant <= 1'b1;
        end else begin
            r_rx_s1  <= RX;
            r_rx_s2  <= r_rx_s1;
            r_rx_ant <= r_rx_s2;
        end
    end

    assign w_borda   = r_rx_ant & ~r_rx_s2;
    assign w_amostra = (r_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Byte decoding is evaluated on the stop-bit sample and registered, so
    // every result pulse and the new dado_recebido are visible together for
    // exactly the DECODIFICA cycle. modo_manual cannot change between the
    // stop sample and DECODIFICA, so gating A/F on it here is equivalent.
    always_comb begin
        w_prox         = r_estado;
        w_carrega_meio = 1'b0;
        w_carrega_bit  = 1'b0;
        w_desloca      = 1'b0;
        w_carga_dado   = 1'b0;
        w_modo_prox    = r_modo;
        w_abre         = 1'b0;
        w_fecha        = 1'b0;
        w_pronto       = 1'b0;
        w_invalido     = 1'b0;
        w_erro_quadro  = 1'b0;
        w_byte_ok      = 1'b0;
`ifdef RX_PARIDADE_EN
        w_amostra_par  = 1'b0;
        w_erro_par     = 1'b0;
`endif

        case (r_estado)
            OCIOSO: begin
                if (w_borda) begin
                    w_prox         = INICIO;
                    w_carrega_meio = 1'b1;
                end
            end

            INICIO: begin
                if (w_amostra) begin
                    if (!r_rx_s2) begin
                        w_prox        = DADOS;
                        w_carrega_bit = 1'b1;
                    end else begin
                        w_prox = OCIOSO;
                    end
                end
            end

            DADOS: begin
                if (w_amostra) begin
                    w_desloca     = 1'b1;
                    w_carrega_bit = 1'b1;
                    if (r_nbit == 3'd7) begin
`ifdef RX_PARIDADE_EN
                        w_prox = PARIDADE;
`else
                        w_prox = PARADA;
`endif
                    end
                end
            end

            PARIDADE: begin
`ifdef RX_PARIDADE_EN
                if (w_amostra) begin
                    w_amostra_par = 1'b1;
                    w_carrega_bit = 1'b1;
                    w_prox        = PARADA;
                end
`else
                w_prox = OCIOSO;
`endif
            end

            PARADA: begin
                if (w_amostra) begin
                    if (r_rx_s2) begin
                        w_prox = DECODIFICA;
`ifdef RX_PARIDADE_EN
                        w_erro_par = r_par_falha;
                        w_byte_ok  = ~r_par_falha;
`else
                        w_byte_ok  = 1'b1;
`endif
                    end else begin
                        w_erro_quadro = 1'b1;
                        w_prox        = ESPERA_ALTO;
                    end
                end
            end

            DECODIFICA: begin
                w_prox = OCIOSO;
            end

            ESPERA_ALTO: begin
                if (r_rx_s2) begin
                    w_prox = OCIOSO;
                end
            end

            default: begin
                w_prox = OCIOSO;
            end
        endcase

        if (w_byte_ok) begin
            w_pronto     = 1'b1;
            w_carga_dado = 1'b1;
            case (r_shift)
                8'h4D, 8'h6D: w_modo_prox = 1'b1;
                8'h55, 8'h75: w_modo_prox = 1'b0;
                8'h41, 8'h61: w_abre      = r_modo;
                8'h46, 8'h66: w_fecha     = r_modo;
                default:      w_invalido  = 1'b1;
            endcase
        end
    end

    // Bit timing: counter reloads on every sample and counts down to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_carrega_meio) begin
            r_cnt <= RECARGA_MEIO;
        end else if (w_carrega_bit) begin
            r_cnt <= RECARGA_BIT;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // LSB-first shift register and data-bit index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_nbit  <= '0;
        end else begin
            if (w_carrega_meio) begin
                r_nbit <= '0;
            end else if (w_desloca) begin
                r_nbit <= r_nbit + 1'b1;
            end
            if (w_desloca) begin
                r_shift <= {r_rx_s2, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dado        <= '0;
            r_modo        <= 1'b0;
            r_abre        <= 1'b0;
            r_fecha       <= 1'b0;
            r_pronto      <= 1'b0;
            r_invalido    <= 1'b0;
            r_erro_quadro <= 1'b0;
        end else begin
            if (w_carga_dado) begin
                r_dado <= r_shift;
            end
            r_modo        <= w_modo_prox;
            r_abre        <= w_abre;
            r_fecha       <= w_fecha;
            r_pronto      <= w_pronto;
            r_invalido    <= w_invalido;
            r_erro_quadro <= w_erro_quadro;
        end
    end

`ifdef RX_PARIDADE_EN
    // Even parity: the parity bit must equal the XOR of the data bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par_falha <= 1'b0;
            r_erro_par  <= 1'b0;
        end else begin
            if (w_amostra_par) begin
                r_par_falha <= (r_rx_s2 != (^r_shift));
            end
            r_erro_par <= w_erro_par;
        end
    end

    assign erro_paridade = r_erro_par;
`else
    assign erro_paridade = 1'b0;
`endif

    assign cmd_abre      = r_abre;
    assign cmd_fecha     = r_fecha;
    assign modo_manual   = r_modo;
    assign dado_recebido = r_dado;
    assign pronto_rx     = r_pronto;
    assign cmd_invalido  = r_invalido;
    assign erro_quadro   = r_erro_quadro;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_rx_comando_valvula.sv
// -----------------------------------------------------------------------------
// tb_rx_comando_valvula
//
// Directed bench for rx_comando_valvula with CICLOS_POR_BIT = 8. A monitor
// counts every cycle each pulse output is high; the stimulus compares the
// change in those counts across each frame with hand-derived expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_comando_valvula;

    localparam int CPB = 8;
`ifdef RX_PARIDADE_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       RX    = 1'b1;
    logic       cmd_abre;
    logic       cmd_fecha;
    logic       modo_manual;
    logic [7:0] dado_recebido;
    logic       pronto_rx;
    logic       cmd_invalido;
    logic       erro_quadro;
    logic       erro_paridade;
    logic [3:0] db_estado;

    rx_comando_valvula #(.CICLOS_POR_BIT(CPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .RX            (RX),
        .cmd_abre      (cmd_abre),
        .cmd_fecha     (cmd_fecha),
        .modo_manual   (modo_manual),
        .dado_recebido (dado_recebido),
        .pronto_rx     (pronto_rx),
        .cmd_invalido  (cmd_invalido),
        .erro_quadro   (erro_quadro),
        .erro_paridade (erro_paridade),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse-high cycle counters, sampled on the falling edge.
    int n_abre = 0, n_fecha = 0, n_pronto = 0, n_inv = 0, n_quadro = 0, n_par = 0, n_ambos = 0;
    logic [7:0] ultimo_dado = 8'h00;

    always @(negedge clock) begin
        if (!reset) begin
            if (cmd_abre)      n_abre++;
            if (cmd_fecha)     n_fecha++;
            if (pronto_rx)     n_pronto++;
            if (cmd_invalido)  n_inv++;
            if (erro_quadro)   n_quadro++;
            if (erro_paridade) n_par++;
            if (cmd_abre && cmd_fecha) n_ambos++;
            if (pronto_rx)     ultimo_dado = dado_recebido;
        end
    end

    int b_abre, b_fecha, b_pronto, b_inv, b_quadro, b_par;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic snap();
        b_abre   = n_abre;
        b_fecha  = n_fecha;
        b_pronto = n_pronto;
        b_inv    = n_inv;
        b_quadro = n_quadro;
        b_par    = n_par;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start, 8 data bits LSB first, optional even parity, stop.
    // RX is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_err);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(CPB);
        end
        if (PAR_EN) begin
            RX = (^b) ^ par_err;
            tick(CPB);
        end
        RX = stop;
        tick(CPB);
    endtask

    initial begin
        // Reset state
        tick(3);
        reset = 1'b0;
        tick(4);
        check("rst_estado", 32'(db_estado), 32'd0);
        check("rst_modo", 32'(modo_manual), 32'd0);
        check("rst_dado", 32'(dado_recebido), 32'h00);
        check("rst_pulsos", 32'({cmd_abre, cmd_fecha, pronto_rx, cmd_invalido, erro_quadro, erro_paridade}), 32'd0);

        // 'A' with manual mode off: accepted silently
        snap();
        send_frame(8'h41, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("A0_pronto", 32'(n_pronto - b_pronto), 32'd1);
        check("A0_dado", 32'(ultimo_dado), 32'h41);
        check("A0_abre", 32'(n_abre - b_abre), 32'd0);
        check("A0_inv", 32'(n_inv - b_inv), 32'd0);
        check("A0_estado", 32'(db_estado), 32'd0);

        // 'M' then 'a' back-to-back
        snap();
        send_frame(8'h4D, 1'b1, 1'b0);
        send_frame(8'h61, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("Ma_pronto", 32'(n_pronto - b_pronto), 32'd2);
        check("Ma_modo", 32'(modo_manual), 32'd1);
        check("Ma_abre", 32'(n_abre - b_abre), 32'd1);
        check("Ma_fecha", 32'(n_fecha - b_fecha), 32'd0);
        check("Ma_dado", 32'(dado_recebido), 32'h61);
        check("Ma_inv", 32'(n_inv - b_inv), 32'd0);

        // 'F' in manual mode
        snap();
        send_frame(8'h46, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("F_fecha", 32'(n_fecha - b_fecha), 32'd1);
        check("F_abre", 32'(n_abre - b_abre), 32'd0);
        check("F_dado", 32'(ultimo_dado), 32'h46);

        // 'U' leaves manual mode without any command pulse
        snap();
        send_frame(8'h55, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("U_modo", 32'(modo_manual), 32'd0);
        check("U_cmd", 32'((n_fecha - b_fecha) + (n_abre - b_abre)), 32'd0);
        check("U_pronto", 32'(n_pronto - b_pronto), 32'd1);
        check("U_inv", 32'(n_inv - b_inv), 32'd0);

        // Non-command byte
        snap();
        send_frame(8'h5A, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("5A_pronto", 32'(n_pronto - b_pronto), 32'd1);
        check("5A_inv", 32'(n_inv - b_inv), 32'd1);
        check("5A_dado", 32'(dado_recebido), 32'h5A);

        // Framing error followed by a 30-cycle break
        snap();
        send_frame(8'h41, 1'b0, 1'b0);
        tick(30);
        check("FE_estado_baixo", 32'(db_estado), 32'd6);
        check("FE_quadro", 32'(n_quadro - b_quadro), 32'd1);
        check("FE_pronto", 32'(n_pronto - b_pronto), 32'd0);
        check("FE_dado", 32'(dado_recebido), 32'h5A);
        RX = 1'b1;
        tick(10);
        check("FE_estado_alto", 32'(db_estado), 32'd0);
        check("FE_sem_pulsos", 32'((n_pronto - b_pronto) + (n_inv - b_inv) + (n_quadro - b_quadro)), 32'd1);

        // 3-cycle glitch on idle line is a false start
        snap();
        RX = 1'b0;
        tick(3);
        RX = 1'b1;
        tick(20);
        check("GL_estado", 32'(db_estado), 32'd0);
        check("GL_pulsos", 32'((n_pronto - b_pronto) + (n_inv - b_inv) + (n_quadro - b_quadro) + (n_abre - b_abre)), 32'd0);

        // Recovery after framing error: a fresh frame is received
        snap();
        send_frame(8'h4D, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("M2_modo", 32'(modo_manual), 32'd1);
        check("M2_dado", 32'(dado_recebido), 32'h4D);

`ifdef RX_PARIDADE_EN
        // Wrong parity leaves mode unchanged; correct parity is accepted
        send_frame(8'h55, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        snap();
        send_frame(8'h4D, 1'b1, 1'b1);
        RX = 1'b1;
        tick(6);
        check("PE_erro", 32'(n_par - b_par), 32'd1);
        check("PE_pronto", 32'(n_pronto - b_pronto), 32'd0);
        check("PE_modo", 32'(modo_manual), 32'd0);
        snap();
        send_frame(8'h4D, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("PO_erro", 32'(n_par - b_par), 32'd0);
        check("PO_modo", 32'(modo_manual), 32'd1);
`endif

        // Reset in the middle of the data bits
        RX = 1'b0;
        tick(CPB);
        RX = 1'b1;
        tick(CPB);
        RX = 1'b0;
        tick(CPB);
        check("RD_estado_dados", 32'(db_estado), 32'd2);
        reset = 1'b1;
        #1;
        check("RD_estado", 32'(db_estado), 32'd0);
        check("RD_modo", 32'(modo_manual), 32'd0);
        check("RD_dado", 32'(dado_recebido), 32'h00);
        check("RD_pulsos", 32'({cmd_abre, cmd_fecha, pronto_rx, cmd_invalido, erro_quadro, erro_paridade}), 32'd0);
        RX = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);

        // Normal operation after reset; 'f' ignored with manual mode off
        snap();
        send_frame(8'h66, 1'b1, 1'b0);
        RX = 1'b1;
        tick(6);
        check("f0_pronto", 32'(n_pronto - b_pronto), 32'd1);
        check("f0_fecha", 32'(n_fecha - b_fecha), 32'd0);
        check("f0_dado", 32'(dado_recebido), 32'h66);

        check("nunca_ambos", 32'(n_ambos), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
